mips_writeback_stage: RTL and testbench
=======================================

Name: mips_writeback_stage

Overview:
MEM/WB pipeline register and writeback formatter that sits directly upstream of the register bank. It drives the bank's RegWrite, WriteReg and WriteData ports.
- Accepts a retiring instruction from the memory stage over a valid/ready handshake.
- Extracts and extends load data (byte/half/word).
- Suppresses writes to $0.
- Tracks halt: raises `done` once a halt instruction retires, and counts retired instructions.

Parameters:
- DATA_W, DATA_32_W (32): datapath width.
- AW, REG_ADDR_W+1: register address width; matches the bank's address ports.
- CNT_W, 32: retired-instruction counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset: 0 = reset.
- in_valid  in  1  memory stage presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_reg_write  in  1  instruction writes a GPR.
- in_mem_to_reg  in  1  1 = load data selected, 0 = ALU result selected.
- in_load_type  in  3  0=LW, 1=LH, 2=LHU, 3=LB, 4=LBU; 5-7 are treated as LW.
- in_addr_lo  in  2  effective address bits [1:0].
- in_alu_result  in  DATA_W  ALU/link result.
- in_mem_rdata  in  DATA_W  raw 32-bit memory word (big-endian byte lanes).
- in_dest  in  AW  destination register.
- in_halt  in  1  instruction is the halt marker.
- stall  in  1  hold request from the hazard unit.
- flush  in  1  kill the in-flight entry.
- RegWrite  out  1  write strobe to the register bank.
- WriteReg  out  AW  bank write address.
- WriteData  out  DATA_W  bank write data.
- done  out  1  halt has retired (sticky).
- retired_cnt  out  CNT_W  count of retired instructions.

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - RegWrite=0, WriteReg=0, WriteData=0.
  - done=0, retired_cnt=0, valid flag=0, state=RUN.
  - Reset asserted mid-operation drops the pending entry; no write is issued after reset asserts.
- FSM states: RUN and HALTED.
  - RUN -> HALTED when an accepted entry with in_halt=1 retires.
  - HALTED exits only on reset.
- Handshake:
  - in_ready = (state==RUN) && !stall && !done.
  - Transfer occurs when in_valid && in_ready.
  - in_ready does not depend on in_valid.
- Latency: an entry accepted at edge N drives RegWrite/WriteReg/WriteData during cycle N+1, for exactly one cycle per accepted entry.
- No-transfer cycles: if no transfer occurs at an edge (idle, stall, or HALTED), the next cycle has RegWrite=0. WriteReg and WriteData hold their last values.
- RegWrite = in_reg_write && (in_dest != 0) from the accepted entry. A write to $0 retires with RegWrite=0.
- Flush:
  - flush=1 at an edge discards any transfer in that cycle: no RegWrite next cycle, no count, no halt.
  - flush has priority over stall and in_valid.
- Data select:
  - in_mem_to_reg=0: WriteData = in_alu_result.
  - in_mem_to_reg=1, lanes are big-endian. Byte k (addr_lo=k) = rdata[31-8k -: 8]. Half at addr_lo[1]=0 is rdata[31:16]; at addr_lo[1]=1 it is rdata[15:0].
    - LB: sign-extend the selected byte.
    - LBU: zero-extend the selected byte.
    - LH: sign-extend the selected half.
    - LHU: zero-extend the selected half.
    - LW: whole word.
- retired_cnt:
  - Increments by 1 per transfer (including $0 and non-writing instructions, and the halt itself).
  - Wraps from 2^CNT_W-1 to 0.
- done:
  - Rises in the cycle after the halt is accepted, the same cycle as any halt writeback.
  - Stays high until reset. in_ready=0 thereafter.
- Simultaneous stall and in_valid: no transfer; the upstream stage holds its inputs.

Optional Feature:
WB_ALIGN_CHECK_EN
- Defined:
  - Adds output align_err (1 bit, sticky, reset 0).
  - A load with LW and in_addr_lo!=0, or LH/LHU and in_addr_lo[0]=1, still retires and counts, but RegWrite=0 and align_err is set.
- Undefined:
  - No align_err port.
  - LW ignores addr_lo; LH/LHU use addr_lo[1] only.

Test Plan:
- Reset mid-stream: assert rst=0 while an entry is pending. Required: RegWrite=0 immediately (asynchronous), retired_cnt=0, done=0; no write after rst returns to 1.
- ALU writeback: accept in_dest=5, alu=0x1234_5678, reg_write=1. Required: next cycle RegWrite=1, WriteReg=5, WriteData=0x12345678 for one cycle; retired_cnt=1.
- Loads on rdata=0x80FF_7F01:
  - LB addr 0 -> 0xFFFFFF80.
  - LBU addr 1 -> 0x000000FF.
  - LB addr 2 -> 0x0000007F.
  - LH addr 2 -> 0x00007F01.
  - LHU addr 0 -> 0x000080FF.
  - LW -> 0x80FF7F01.
- $0 and flush:
  - in_dest=0 with reg_write=1: RegWrite stays 0, count +1.
  - in_valid=1 with flush=1: no write, count unchanged.
  - in_valid=1 with stall=1: in_ready=0, no transfer.
- Halt: accept in_halt=1 at edge N. Required: done=1 from cycle N+1 and in_ready=0; a following in_valid produces no writes and no count change.
- Counter wrap (CNT_W=4): 16 transfers return retired_cnt to 0. With WB_ALIGN_CHECK_EN defined, LW at addr 2 gives RegWrite=0 and align_err=1.

Source files
------------

// File: rtl/mips_writeback_stage_if.sv
// Retiring-instruction channel from the memory stage into the MEM/WB register.
// master = memory stage (producer), slave = writeback stage (consumer).
interface mips_writeback_stage_if #(
  parameter int DATA_W = 32,
  parameter int AW     = 5
);
  logic              in_valid;
  logic              in_ready;
  logic              in_reg_write;
  logic              in_mem_to_reg;
  logic [2:0]        in_load_type;
  logic [1:0]        in_addr_lo;
  logic [DATA_W-1:0] in_alu_result;
  logic [DATA_W-1:0] in_mem_rdata;
  logic [AW-1:0]     in_dest;
  logic              in_halt;

  modport master (
    output in_valid, in_reg_write, in_mem_to_reg, in_load_type, in_addr_lo,
           in_alu_result, in_mem_rdata, in_dest, in_halt,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_reg_write, in_mem_to_reg, in_load_type, in_addr_lo,
           in_alu_result, in_mem_rdata, in_dest, in_halt,
    output in_ready
  );
endinterface

// File: rtl/mips_writeback_stage.sv
// MEM/WB register and load formatter driving the register bank write port.
// Optional macro WB_ALIGN_CHECK_EN adds a sticky align_err output and blocks misaligned load writes.
module mips_writeback_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4,
  parameter int AW         = REG_ADDR_W + 1,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  mips_writeback_stage_if.slave up,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  RegWrite,
  output logic [AW-1:0]         WriteReg,
  output logic [DATA_W-1:0]     WriteData,
  output logic                  done,
  output logic [CNT_W-1:0]      retired_cnt
`ifdef WB_ALIGN_CHECK_EN
  ,
  output logic                  align_err
`endif
);

  // state   | meaning
  // RUN     | accepting retiring instructions
  // HALTED  | halt retired; input closed until reset
  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

  localparam logic [2:0] LT_LH  = 3'd1;
  localparam logic [2:0] LT_LHU = 3'd2;
  localparam logic [2:0] LT_LB  = 3'd3;
  localparam logic [2:0] LT_LBU = 3'd4;

  logic [0:0]        state;
  logic              xfer;
  logic              misalign;
  logic [7:0]        byteSel;
  logic [15:0]       halfSel;
  logic [DATA_W-1:0] loadData;
  logic [DATA_W-1:0] wbData;

  assign up.in_ready = (state == ST_RUN) && !stall && !done;
  assign xfer        = up.in_valid && up.in_ready && !flush;

  // Big-endian lanes: addr_lo 0 selects the most significant byte.
  always_comb begin
    byteSel = up.in_mem_rdata[31:24];
    case (up.in_addr_lo)
      2'd0: byteSel = up.in_mem_rdata[31:24];
      2'd1: byteSel = up.in_mem_rdata[23:16];
      2'd2: byteSel = up.in_mem_rdata[15:8];
      2'd3: byteSel = up.in_mem_rdata[7:0];
      default: byteSel = up.in_mem_rdata[31:24];
    endcase
    halfSel = up.in_addr_lo[1] ? up.in_mem_rdata[15:0] : up.in_mem_rdata[31:16];

    case (up.in_load_type)
      LT_LH:   loadData = {{(DATA_W-16){halfSel[15]}}, halfSel};
      LT_LHU:  loadData = {{(DATA_W-16){1'b0}}, halfSel};
      LT_LB:   loadData = {{(DATA_W-8){byteSel[7]}}, byteSel};
      LT_LBU:  loadData = {{(DATA_W-8){1'b0}}, byteSel};
      default: loadData = up.in_mem_rdata;
    endcase
    wbData = up.in_mem_to_reg ? loadData : up.in_alu_result;
  end

`ifdef WB_ALIGN_CHECK_EN
  always_comb begin
    misalign = 1'b0;
    if (up.in_mem_to_reg) begin
      case (up.in_load_type)
        LT_LH, LT_LHU:  misalign = up.in_addr_lo[0];
        LT_LB, LT_LBU:  misalign = 1'b0;
        default:        misalign = (up.in_addr_lo != 2'd0);
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      align_err <= 1'b0;
    else if (xfer && misalign)
      align_err <= 1'b1;
  end
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_RUN;
      RegWrite    <= 1'b0;
      WriteReg    <= '0;
      WriteData   <= '0;
      done        <= 1'b0;
      retired_cnt <= '0;
    end else if (xfer) begin
      RegWrite    <= up.in_reg_write && (up.in_dest != '0) && !misalign;
      WriteReg    <= up.in_dest;
      WriteData   <= wbData;
      retired_cnt <= retired_cnt + 1'b1;
      if (up.in_halt) begin
        state <= ST_HALTED;
        done  <= 1'b1;
      end
    end else begin
      RegWrite <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_writeback_stage.sv
// Directed bench for mips_writeback_stage with an expected-writeback scoreboard.
// Define WB_ALIGN_CHECK_EN to also exercise the alignment check.
module tb_mips_writeback_stage;
  localparam int DATA_W = 32;
  localparam int AW     = 5;
  localparam int CNT_W  = 4;

  typedef struct packed {
    logic              rw;
    logic [AW-1:0]     wreg;
    logic [DATA_W-1:0] data;
  } wb_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              stall, flush;
  logic              RegWrite;
  logic [AW-1:0]     WriteReg;
  logic [DATA_W-1:0] WriteData;
  logic              done;
  logic [CNT_W-1:0]  retired_cnt;
`ifdef WB_ALIGN_CHECK_EN
  logic              align_err;
`endif

  mips_writeback_stage_if #(.DATA_W(DATA_W), .AW(AW)) up ();

  mips_writeback_stage #(.DATA_W(DATA_W), .REG_ADDR_W(AW-1), .AW(AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .up(up), .stall(stall), .flush(flush),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
    .done(done), .retired_cnt(retired_cnt)
`ifdef WB_ALIGN_CHECK_EN
    , .align_err(align_err)
`endif
  );

  always #5 clk = ~clk;

  wb_t               sbq[$];
  int                checks = 0;
  int                errors = 0;
  logic [CNT_W-1:0]  expCnt;
  logic              expDone;
  logic              expAlign;
  logic [AW-1:0]     lastReg;
  logic [DATA_W-1:0] lastData;

  function automatic logic [31:0] modelData(input logic m2r, input logic [2:0] lt,
                                            input logic [1:0] alo, input logic [31:0] alu,
                                            input logic [31:0] rd);
    logic [31:0] sh;
    if (!m2r) return alu;
    case (lt)
      3'd1: begin sh = rd >> (alo[1] ? 0 : 16); return {{16{sh[15]}}, sh[15:0]}; end
      3'd2: begin sh = rd >> (alo[1] ? 0 : 16); return {16'h0, sh[15:0]}; end
      3'd3: begin sh = rd >> (8 * (3 - int'(alo))); return {{24{sh[7]}}, sh[7:0]}; end
      3'd4: begin sh = rd >> (8 * (3 - int'(alo))); return {24'h0, sh[7:0]}; end
      default: return rd;
    endcase
  endfunction

  function automatic logic modelMis(input logic m2r, input logic [2:0] lt, input logic [1:0] alo);
`ifdef WB_ALIGN_CHECK_EN
    if (!m2r) return 1'b0;
    if (lt == 3'd1 || lt == 3'd2) return alo[0];
    if (lt == 3'd3 || lt == 3'd4) return 1'b0;
    return alo != 2'd0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic m2r, input logic [2:0] lt,
                       input logic [1:0] alo, input logic [31:0] alu, input logic [31:0] rd,
                       input logic [AW-1:0] dest, input logic halt, input logic st,
                       input logic fl);
    up.in_valid = v;        up.in_reg_write = rw;   up.in_mem_to_reg = m2r;
    up.in_load_type = lt;   up.in_addr_lo = alo;    up.in_alu_result = alu;
    up.in_mem_rdata = rd;   up.in_dest = dest;      up.in_halt = halt;
    stall = st;             flush = fl;
  endtask

  task automatic step(input string name, input logic v, input logic rw, input logic m2r,
                      input logic [2:0] lt, input logic [1:0] alo, input logic [31:0] alu,
                      input logic [31:0] rd, input logic [AW-1:0] dest, input logic halt,
                      input logic st, input logic fl);
    logic rdyExp, xfer, mis;
    wb_t  e, got;
    drive(v, rw, m2r, lt, alo, alu, rd, dest, halt, st, fl);
    #1;
    rdyExp = !expDone && !st;
    check({name, ":in_ready"}, {31'b0, up.in_ready}, {31'b0, rdyExp});
    xfer = v && rdyExp && !fl;
    if (xfer) begin
      mis    = modelMis(m2r, lt, alo);
      e.rw   = rw && (dest != '0) && !mis;
      e.wreg = dest;
      e.data = modelData(m2r, lt, alo, alu, rd);
      sbq.push_back(e);
      expCnt = expCnt + 1'b1;
      if (halt) expDone = 1'b1;
      if (mis) expAlign = 1'b1;
    end
    @(posedge clk);
    #1;
    if (sbq.size() > 0) begin
      got = sbq.pop_front();
      check({name, ":RegWrite"}, {31'b0, RegWrite}, {31'b0, got.rw});
      check({name, ":WriteReg"}, {27'b0, WriteReg}, {27'b0, got.wreg});
      check({name, ":WriteData"}, WriteData, got.data);
      lastReg  = got.wreg;
      lastData = got.data;
    end else begin
      check({name, ":RegWrite"}, {31'b0, RegWrite}, 32'h0);
      check({name, ":WriteReg"}, {27'b0, WriteReg}, {27'b0, lastReg});
      check({name, ":WriteData"}, WriteData, lastData);
    end
    check({name, ":retired_cnt"}, {28'b0, retired_cnt}, {28'b0, expCnt});
    check({name, ":done"}, {31'b0, done}, {31'b0, expDone});
`ifdef WB_ALIGN_CHECK_EN
    check({name, ":align_err"}, {31'b0, align_err}, {31'b0, expAlign});
`endif
  endtask

  task automatic idle(input string name);
    step(name, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 32'h0, 32'h0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // Asserts reset mid-cycle, checks async clear, then releases on a falling edge.
  task automatic doReset(input string name);
    rst = 1'b0;
    #1;
    check({name, ":RegWrite"}, {31'b0, RegWrite}, 32'h0);
    check({name, ":retired_cnt"}, {28'b0, retired_cnt}, 32'h0);
    check({name, ":done"}, {31'b0, done}, 32'h0);
    check({name, ":WriteData"}, WriteData, 32'h0);
    sbq.delete();
    expCnt = '0; expDone = 1'b0; expAlign = 1'b0; lastReg = '0; lastData = '0;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 32'h0, 32'h0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  localparam logic [31:0] RD = 32'h80FF_7F01;

  initial begin
    drive(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 32'h0, 32'h0, '0, 1'b0, 1'b0, 1'b0);
    #2;
    doReset("reset");

    step("alu", 1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h1234_5678, 32'h0, 5'd5, 1'b0, 1'b0, 1'b0);
    idle("alu_one_cycle");

    step("lb0",  1'b1, 1'b1, 1'b1, 3'd3, 2'd0, 32'hDEAD_BEEF, RD, 5'd1, 1'b0, 1'b0, 1'b0);
    step("lbu1", 1'b1, 1'b1, 1'b1, 3'd4, 2'd1, 32'hDEAD_BEEF, RD, 5'd2, 1'b0, 1'b0, 1'b0);
    step("lb2",  1'b1, 1'b1, 1'b1, 3'd3, 2'd2, 32'hDEAD_BEEF, RD, 5'd3, 1'b0, 1'b0, 1'b0);
    step("lb3",  1'b1, 1'b1, 1'b1, 3'd3, 2'd3, 32'hDEAD_BEEF, RD, 5'd4, 1'b0, 1'b0, 1'b0);
    step("lh2",  1'b1, 1'b1, 1'b1, 3'd1, 2'd2, 32'hDEAD_BEEF, RD, 5'd6, 1'b0, 1'b0, 1'b0);
    step("lh0",  1'b1, 1'b1, 1'b1, 3'd1, 2'd0, 32'hDEAD_BEEF, RD, 5'd7, 1'b0, 1'b0, 1'b0);
    step("lhu0", 1'b1, 1'b1, 1'b1, 3'd2, 2'd0, 32'hDEAD_BEEF, RD, 5'd8, 1'b0, 1'b0, 1'b0);
    step("lw",   1'b1, 1'b1, 1'b1, 3'd0, 2'd0, 32'hDEAD_BEEF, RD, 5'd9, 1'b0, 1'b0, 1'b0);
    step("lt7",  1'b1, 1'b1, 1'b1, 3'd7, 2'd0, 32'hDEAD_BEEF, RD, 5'd10, 1'b0, 1'b0, 1'b0);
    step("norw", 1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 32'h0000_00AA, RD, 5'd11, 1'b0, 1'b0, 1'b0);

    step("dest0", 1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'hCAFE_F00D, RD, 5'd0, 1'b0, 1'b0, 1'b0);
    step("flush", 1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h1111_1111, RD, 5'd12, 1'b0, 1'b0, 1'b1);
    step("stall", 1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h2222_2222, RD, 5'd13, 1'b0, 1'b1, 1'b0);
    step("stflush", 1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h3333_3333, RD, 5'd14, 1'b1, 1'b1, 1'b1);
    step("flhalt", 1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h4444_4444, RD, 5'd15, 1'b1, 1'b0, 1'b1);

    step("pending", 1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h5555_5555, RD, 5'd16, 1'b0, 1'b0, 1'b0);
    doReset("midrst");
    idle("post_rst");

    step("pre_halt", 1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0000_0042, RD, 5'd17, 1'b0, 1'b0, 1'b0);
    step("halt", 1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0000_0099, RD, 5'd18, 1'b1, 1'b0, 1'b0);
    step("after_halt", 1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0000_0077, RD, 5'd19, 1'b0, 1'b0, 1'b0);
    step("after_halt2", 1'b1, 1'b1, 1'b1, 3'd3, 2'd1, 32'h0, RD, 5'd20, 1'b0, 1'b0, 1'b0);

    doReset("rst_wrap");
    for (int i = 0; i < 16; i++)
      step("wrap", 1'b1, 1'b1, 1'b0, 3'd0, 2'd0, $urandom, RD, AW'(i + 1), 1'b0, 1'b0, 1'b0);
    check("wrap_zero", {28'b0, retired_cnt}, 32'h0);

`ifdef WB_ALIGN_CHECK_EN
    step("lw_a2", 1'b1, 1'b1, 1'b1, 3'd0, 2'd2, 32'h0, RD, 5'd21, 1'b0, 1'b0, 1'b0);
    step("lh_a1", 1'b1, 1'b1, 1'b1, 3'd1, 2'd1, 32'h0, RD, 5'd22, 1'b0, 1'b0, 1'b0);
    step("lb_a1", 1'b1, 1'b1, 1'b1, 3'd3, 2'd1, 32'h0, RD, 5'd23, 1'b0, 1'b0, 1'b0);
`else
    step("lw_a2", 1'b1, 1'b1, 1'b1, 3'd0, 2'd2, 32'h0, RD, 5'd21, 1'b0, 1'b0, 1'b0);
    step("lh_a3", 1'b1, 1'b1, 1'b1, 3'd2, 2'd3, 32'h0, RD, 5'd22, 1'b0, 1'b0, 1'b0);
`endif
    idle("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
